// File: rtl/aes_sbox_lookup_engine.sv
// aes_sbox_lookup_engine
//   Applies SubBytes / InvSubBytes to a 128-bit AES state by looking every byte
//   up in an external dual-port S-box RAM (addr[8] selects the inverse table).
//   Two bytes per cycle: port A serves even bytes, port B odd bytes, eight
//   issue cycles per state. One state in flight at a time.
// Ports
//   clk, rst_n               clock, async active-low reset
//   in_valid/in_ready        input handshake; in_state (128b), in_inverse
//   out_valid/out_ready      output handshake; out_state (128b), held until taken
//   ram_ce, ram_oce          RAM clock enable / output-register enable (both ports)
//   ram_ada, ram_adb         9-bit port addresses {inv, byte}
//   ram_douta, ram_doutb     RAM read data
// Parameter
//   RAM_LATENCY              1 = bypass read, 2 = output-register read

// One RAM port: drives the address for byte 2k+lane and collects the returned
// substitution into its slice of the result.
module aes_sbox_lookup_lane (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0][7:0] bytes_i,
  input  logic [2:0]      k_i,
  input  logic            inv_i,
  input  logic            cap_i,
  input  logic [2:0]      cap_tag_i,
  input  logic [7:0]      dout_i,
  output logic [8:0]      addr_o,
  output logic [7:0][7:0] res_o
);
  logic [7:0][7:0] res_q;

  // k stays at 7 outside ISSUE, so the address holds its last value in DRAIN.
  assign addr_o = {inv_i, bytes_i[k_i]};
  assign res_o  = res_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     res_q <= '0;
    else if (cap_i) res_q[cap_tag_i] <= dout_i;
  end
endmodule

module aes_sbox_lookup_engine #(
  parameter int RAM_LATENCY = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inverse,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         ram_ce,
  output logic         ram_oce,
  output logic [8:0]   ram_ada,
  output logic [8:0]   ram_adb,
  input  logic [7:0]   ram_douta,
  input  logic [7:0]   ram_doutb
);
  localparam int NUM_LANES = 2;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e       state_q, state_d;
  logic [2:0]   k_q, k_d;
  logic         started_q;
  logic         inv_q;
  logic [127:0] st_q;

  // Issue tag shift register: stage i is the lookup issued i cycles ago.
  logic [RAM_LATENCY:1]      vld_pipe;
  logic [RAM_LATENCY:1][2:0] tag_pipe;

  logic       issue, accept, cap;
  logic [2:0] cap_tag;

  logic [NUM_LANES-1:0][7:0][7:0] lane_bytes, lane_res;
  logic [NUM_LANES-1:0][8:0]      lane_addr;
  logic [NUM_LANES-1:0][7:0]      lane_dout;

  assign issue   = (state_q == ISSUE);
  assign accept  = in_valid && in_ready;
  assign cap     = vld_pipe[RAM_LATENCY];
  assign cap_tag = tag_pipe[RAM_LATENCY];

  // in_ready is held low through reset and rises on the first edge after it.
  assign in_ready  = started_q && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign ram_ce    = (state_q == ISSUE) || (state_q == DRAIN);
  assign ram_oce   = ram_ce;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      IDLE:    if (accept) begin state_d = ISSUE; k_d = '0; end
      ISSUE:   if (k_q == 3'd7) state_d = DRAIN;
               else             k_d = k_q + 3'd1;
      DRAIN:   if (cap && cap_tag == 3'd7) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      k_q       <= '0;
      started_q <= 1'b0;
      inv_q     <= 1'b0;
      st_q      <= '0;
      vld_pipe  <= '0;
      tag_pipe  <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      started_q   <= 1'b1;
      vld_pipe[1] <= issue;
      tag_pipe[1] <= k_q;
      for (int i = 2; i <= RAM_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
      if (accept) begin
        st_q  <= in_state;
        inv_q <= in_inverse;
      end
    end
  end

  assign ram_ada      = lane_addr[0];
  assign ram_adb      = lane_addr[1];
  assign lane_dout[0] = ram_douta;
  assign lane_dout[1] = ram_doutb;

  // Lane l owns state bytes 2j+l, j = 0..7.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    for (genvar j = 0; j < 8; j++) begin : g_byte
      assign lane_bytes[l][j]              = st_q[(2*j+l)*8 +: 8];
      assign out_state[(2*j+l)*8 +: 8]     = lane_res[l][j];
    end
    aes_sbox_lookup_lane u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .bytes_i   (lane_bytes[l]),
      .k_i       (k_q),
      .inv_i     (inv_q),
      .cap_i     (cap),
      .cap_tag_i (cap_tag),
      .dout_i    (lane_dout[l]),
      .addr_o    (lane_addr[l]),
      .res_o     (lane_res[l])
    );
  end
endmodule

// File: tb/tb_aes_sbox_lookup_engine.sv
module tb_aes_sbox_lookup_engine;
  localparam logic [127:0] FIPS_IN  = 128'hFFEEDDCCBBAA99887766554433221100;
  localparam logic [127:0] FIPS_OUT = 128'h1628C14BEAACEEC4F533FC1BC3938263;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT 1: RAM_LATENCY = 1
  logic         in_valid, in_ready, in_inverse, out_valid, out_ready, ram_ce, ram_oce;
  logic [127:0] in_state, out_state;
  logic [8:0]   ram_ada, ram_adb;
  logic [7:0]   ram_douta, ram_doutb;
  // DUT 2: RAM_LATENCY = 2
  logic         in_valid2, in_ready2, in_inverse2, out_valid2, out_ready2, ram_ce2, ram_oce2;
  logic [127:0] in_state2, out_state2;
  logic [8:0]   ram_ada2, ram_adb2;
  logic [7:0]   ram_douta2, ram_doutb2, rega2, regb2;

  logic [7:0] tab [0:511];

  aes_sbox_lookup_engine #(.RAM_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .in_inverse(in_inverse), .out_valid(out_valid),
    .out_ready(out_ready), .out_state(out_state), .ram_ce(ram_ce), .ram_oce(ram_oce),
    .ram_ada(ram_ada), .ram_adb(ram_adb), .ram_douta(ram_douta), .ram_doutb(ram_doutb));

  aes_sbox_lookup_engine #(.RAM_LATENCY(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_state(in_state2), .in_inverse(in_inverse2), .out_valid(out_valid2),
    .out_ready(out_ready2), .out_state(out_state2), .ram_ce(ram_ce2), .ram_oce(ram_oce2),
    .ram_ada(ram_ada2), .ram_adb(ram_adb2), .ram_douta(ram_douta2), .ram_doutb(ram_doutb2));

  // RAM models: bypass read for dut1, output-register read for dut2.
  always @(posedge clk) begin
    if (ram_ce) begin
      ram_douta <= tab[ram_ada];
      ram_doutb <= tab[ram_adb];
    end
    if (ram_ce2) begin
      rega2 <= tab[ram_ada2];
      regb2 <= tab[ram_adb2];
    end
    if (ram_oce2) begin
      ram_douta2 <= rega2;
      ram_doutb2 <= regb2;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] w = {b, b} << n;
    return w[15:8];
  endfunction

  task automatic build_tables();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      tab[x] = s;
      tab[256 + int'(s)] = 8'(x);
    end
  endtask

  // One transaction on dut1: latency, per-cycle addresses, busy ready, result,
  // optional 20-cycle backpressure with ignored in_valid pulses, handshake.
  task automatic run_op(input string nm, input logic [127:0] st, input logic inv,
                        input logic [127:0] exp, input bit bp);
    int cyc, w;
    bit ok_addr, ok_busy, ok_hold;
    w = 0;
    while (!in_ready && w < 20) begin @(negedge clk); w++; end
    chk({nm, "_ready_wait"}, 128'(in_ready), 128'(1));
    in_state = st; in_inverse = inv; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_state = ~st; in_inverse = ~inv;
    cyc = 0; ok_addr = 1'b1; ok_busy = 1'b1;
    while (!out_valid && cyc < 40) begin
      if (cyc < 8 && !(ram_ce && ram_oce && ram_ada == {inv, st[16*cyc +: 8]} &&
                       ram_adb == {inv, st[16*cyc+8 +: 8]})) ok_addr = 1'b0;
      if (in_ready) ok_busy = 1'b0;
      @(negedge clk); cyc++;
    end
    chk({nm, "_latency"}, 128'(cyc), 128'(9));
    chk({nm, "_issue_addr"}, 128'(ok_addr), 128'(1));
    chk({nm, "_busy_noready"}, 128'(ok_busy), 128'(1));
    chk({nm, "_result"}, out_state, exp);
    chk({nm, "_done_idle"}, {125'(0), in_ready, ram_ce, ram_oce}, 128'(0));
    if (bp) begin
      ok_hold = 1'b1;
      for (int j = 0; j < 20; j++) begin
        in_valid = j[0]; in_state = {4{$urandom}};
        if (!(out_valid && out_state == exp && !in_ready && !ram_ce)) ok_hold = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b0;
      chk({nm, "_bp_hold"}, 128'(ok_hold), 128'(1));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, "_handshake"}, {126'(0), out_valid, in_ready}, 128'(1));
  endtask

  typedef struct {
    logic [127:0] st;
    logic         inv;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int cyc;
    bit ok;
    vecs[0] = '{st: 128'h0,             inv: 1'b0, exp: {16{8'h63}}};
    vecs[1] = '{st: FIPS_IN,            inv: 1'b0, exp: FIPS_OUT};
    vecs[2] = '{st: FIPS_OUT,           inv: 1'b1, exp: FIPS_IN};
    vecs[3] = '{st: {16{8'hFF}},        inv: 1'b0, exp: {16{8'h16}}};
    vecs[4] = '{st: {16{8'h63}},        inv: 1'b1, exp: 128'h0};
    vecs[5] = '{st: 128'h0,             inv: 1'b1, exp: {16{8'h52}}};

    build_tables();
    in_valid = 0; in_state = '0; in_inverse = 0; out_ready = 0;
    in_valid2 = 0; in_state2 = '0; in_inverse2 = 0; out_ready2 = 0;
    ram_douta = '0; ram_doutb = '0; ram_douta2 = '0; ram_doutb2 = '0; rega2 = '0; regb2 = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_state", out_state, 128'h0);
    chk("rst_ram_en", {126'(0), ram_ce, ram_oce}, 128'(0));
    chk("rst_ram_addr", {110'(0), ram_ada, ram_adb}, 128'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 128'(in_ready), 128'(1));

    // out_ready while idle does nothing
    out_ready = 1'b1;
    ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (out_valid || !in_ready || ram_ce) ok = 1'b0;
    end
    out_ready = 1'b0;
    chk("idle_out_ready", 128'(ok), 128'(1));

    // Directed vectors
    for (int i = 0; i < 6; i++)
      run_op($sformatf("vec%0d", i), vecs[i].st, vecs[i].inv, vecs[i].exp, 1'b0);

    // Backpressure, then a follow-up op to show the busy pulses were ignored
    run_op("bp", FIPS_IN, 1'b0, FIPS_OUT, 1'b1);
    run_op("after_bp", FIPS_OUT, 1'b1, FIPS_IN, 1'b0);

    // Reset in the middle of ISSUE (k=4)
    in_state = FIPS_IN; in_inverse = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("midop_k4_addr", 128'(ram_ada), 128'({1'b0, 8'h88}));
    rst_n = 1'b0;
    #1;
    chk("midop_rst_out", {125'(0), out_valid, in_ready, ram_ce}, 128'(0));
    chk("midop_rst_state", out_state, 128'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (out_valid || !in_ready || ram_ce) ok = 1'b0;
    end
    chk("midop_release_quiet", 128'(ok), 128'(1));
    run_op("midop_next", 128'h0, 1'b0, {16{8'h63}}, 1'b0);

    // RAM_LATENCY = 2 instance
    in_state2 = FIPS_IN; in_inverse2 = 1'b0; in_valid2 = 1'b1;
    @(negedge clk);
    in_valid2 = 1'b0; in_state2 = '0;
    cyc = 0;
    while (!out_valid2 && cyc < 40) begin @(negedge clk); cyc++; end
    chk("lat2_latency", 128'(cyc), 128'(10));
    chk("lat2_result", out_state2, FIPS_OUT);
    out_ready2 = 1'b1;
    @(negedge clk);
    out_ready2 = 1'b0;
    chk("lat2_handshake", {126'(0), out_valid2, in_ready2}, 128'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
